data_cache_assoc: RTL and testbench

Blocking, parametrised N-way set-associative write-back data cache with byte-enabled stores and an integrated miss handler.
- Sits between the load/store unit and the memory/L2 port.
- Extends the direct-mapped, externally-repaired data cache: associativity, a dirty-victim writeback path, a refill FSM and valid/ready handshakes on both sides.
- One outstanding core request at a time.

---
 rtl/data_cache_assoc.sv | 240 ++++++++++++++++++++++++
 tb/tb_data_cache_assoc.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_assoc.sv
`default_nettype none
// ============================================================================
// Module  : data_cache_assoc
// Brief   : Blocking N-way set-associative write-back data cache with
//           byte-enabled stores, round-robin replacement and refill/writeback FSM.
// Rev     : 1.0
// ============================================================================
module data_cache_assoc #(
    parameter int NUM_SETS   = 64,
    parameter int WAYS       = 2,
    parameter int BLOCK_SIZE = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_req_valid_i,
    output logic                  core_req_ready_o,
    input  logic                  core_req_we_i,
    input  logic [31:0]           core_req_addr_i,
    input  logic [31:0]           core_req_wdata_i,
    input  logic [3:0]            core_req_be_i,
    output logic                  core_resp_valid_o,
    output logic [31:0]           core_resp_rdata_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic                  mem_req_we_o,
    output logic [31:0]           mem_req_addr_o,
    output logic [BLOCK_SIZE-1:0] mem_req_wdata_o,
    input  logic                  mem_resp_valid_i,
    input  logic [BLOCK_SIZE-1:0] mem_resp_data_i
);

    localparam int c_WORDS    = BLOCK_SIZE / 32;
    localparam int c_WOFF_W   = $clog2(c_WORDS);
    localparam int c_IDX_W    = $clog2(NUM_SETS);
    localparam int c_LINE_OFF = c_WOFF_W + 2;
    localparam int c_TAG_W    = 32 - c_IDX_W - c_LINE_OFF;
    localparam int c_WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_WB_REQ  = 3'd2,
        ST_RF_REQ  = 3'd3,
        ST_RF_WAIT = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_we;
    logic [31:2]           r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_be;
    logic [c_WAY_W-1:0]    r_victim;
    logic                  r_resp_valid;
    logic [31:0]           r_resp_rdata;

    logic [WAYS-1:0]       r_valid [NUM_SETS];
    logic [WAYS-1:0]       r_dirty [NUM_SETS];
    logic [c_WAY_W-1:0]    r_ptr   [NUM_SETS];
    logic [c_TAG_W-1:0]    r_tag   [NUM_SETS][WAYS];
    logic [BLOCK_SIZE-1:0] r_data  [NUM_SETS][WAYS];

    logic [c_IDX_W-1:0]    w_idx;
    logic [c_TAG_W-1:0]    w_tag;
    int                    w_word_base;
    logic                  w_hit;
    logic [c_WAY_W-1:0]    w_hit_way;
    logic                  w_has_free;
    logic [c_WAY_W-1:0]    w_free_way;
    logic [c_WAY_W-1:0]    w_victim;
    logic                  w_victim_dirty;
    logic [BLOCK_SIZE-1:0] w_hit_line;
    logic [BLOCK_SIZE-1:0] w_merged;
    logic [31:0]           w_load_word;

    assign w_idx = r_addr[c_LINE_OFF +: c_IDX_W];
    assign w_tag = r_addr[c_LINE_OFF + c_IDX_W +: c_TAG_W];

    generate
        if (c_WOFF_W > 0) begin : g_word_sel
            assign w_word_base = 32 * int'(r_addr[2 +: c_WOFF_W]);
        end else begin : g_word_fixed
            assign w_word_base = 0;
        end
    endgenerate

    // Descending scan so the lowest-index matching/free way wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_has_free = 1'b0;
        w_free_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (r_valid[w_idx][i] && (r_tag[w_idx][i] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = c_WAY_W'(i);
            end
            if (!r_valid[w_idx][i]) begin
                w_has_free = 1'b1;
                w_free_way = c_WAY_W'(i);
            end
        end
        w_victim       = w_has_free ? w_free_way : r_ptr[w_idx];
        w_victim_dirty = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];
    end

    always_comb begin
        w_hit_line  = r_data[w_idx][w_hit_way];
        w_load_word = w_hit_line[w_word_base +: 32];
        w_merged    = w_hit_line;
        for (int b = 0; b < 4; b++) begin
            if (r_be[b]) begin
                w_merged[w_word_base + 8 * b +: 8] = r_wdata[8 * b +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        core_req_ready_o = 1'b0;
        mem_req_valid_o  = 1'b0;
        mem_req_we_o     = 1'b0;
        mem_req_addr_o   = '0;
        mem_req_wdata_o  = '0;
        case (r_state)
            ST_IDLE: begin
                core_req_ready_o = 1'b1;
                if (core_req_valid_i) begin
                    w_state_nxt = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (w_hit) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_victim_dirty) begin
                    w_state_nxt = ST_WB_REQ;
                end else begin
                    w_state_nxt = ST_RF_REQ;
                end
            end
            ST_WB_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_we_o    = 1'b1;
                mem_req_addr_o  = {r_tag[w_idx][r_victim], w_idx, {c_LINE_OFF{1'b0}}};
                mem_req_wdata_o = r_data[w_idx][r_victim];
                if (mem_req_ready_i) begin
                    w_state_nxt = ST_RF_REQ;
                end
            end
            ST_RF_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = {r_addr[31:c_LINE_OFF], {c_LINE_OFF{1'b0}}};
                if (mem_req_ready_i) begin
                    w_state_nxt = ST_RF_WAIT;
                end
            end
            ST_RF_WAIT: begin
                if (mem_resp_valid_i) begin
                    w_state_nxt = ST_LOOKUP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_victim     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_ptr[s]   <= '0;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (core_req_valid_i) begin
                        r_we    <= core_req_we_i;
                        r_addr  <= core_req_addr_i[31:2];
                        r_wdata <= core_req_wdata_i;
                        r_be    <= core_req_be_i;
                    end
                end
                ST_LOOKUP: begin
                    if (w_hit) begin
                        r_resp_valid <= 1'b1;
                        if (r_we) begin
                            r_dirty[w_idx][w_hit_way] <= 1'b1;
                        end else begin
                            r_resp_rdata <= w_load_word;
                        end
                    end else begin
                        r_victim <= w_victim;
                        // Pointer moves only when it actually chose the victim.
                        if (!w_has_free && (WAYS > 1)) begin
                            r_ptr[w_idx] <= r_ptr[w_idx] + 1'b1;
                        end
                    end
                end
                ST_RF_WAIT: begin
                    if (mem_resp_valid_i) begin
                        r_valid[w_idx][r_victim] <= 1'b1;
                        r_dirty[w_idx][r_victim] <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Line payload and tags need no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if ((r_state == ST_LOOKUP) && w_hit && r_we) begin
            r_data[w_idx][w_hit_way] <= w_merged;
        end
        if ((r_state == ST_RF_WAIT) && mem_resp_valid_i) begin
            r_data[w_idx][r_victim] <= mem_resp_data_i;
            r_tag[w_idx][r_victim]  <= w_tag;
        end
    end

    assign core_resp_valid_o = r_resp_valid;
    assign core_resp_rdata_o = r_resp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_cache_assoc.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_cache_assoc
// Brief   : Self-checking bench for data_cache_assoc with a behavioural memory.
// Rev     : 1.0
// ============================================================================
module tb_data_cache_assoc;

    localparam int NUM_SETS   = 64;
    localparam int WAYS       = 2;
    localparam int BLOCK_SIZE = 128;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  core_req_valid_i;
    logic                  core_req_ready_o;
    logic                  core_req_we_i;
    logic [31:0]           core_req_addr_i;
    logic [31:0]           core_req_wdata_i;
    logic [3:0]            core_req_be_i;
    logic                  core_resp_valid_o;
    logic [31:0]           core_resp_rdata_o;
    logic                  mem_req_valid_o;
    logic                  mem_req_ready_i;
    logic                  mem_req_we_o;
    logic [31:0]           mem_req_addr_o;
    logic [BLOCK_SIZE-1:0] mem_req_wdata_o;
    logic                  mem_resp_valid_i;
    logic [BLOCK_SIZE-1:0] mem_resp_data_i;

    always #5 clk = ~clk;

    data_cache_assoc #(
        .NUM_SETS   (NUM_SETS),
        .WAYS       (WAYS),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .core_req_valid_i  (core_req_valid_i),
        .core_req_ready_o  (core_req_ready_o),
        .core_req_we_i     (core_req_we_i),
        .core_req_addr_i   (core_req_addr_i),
        .core_req_wdata_i  (core_req_wdata_i),
        .core_req_be_i     (core_req_be_i),
        .core_resp_valid_o (core_resp_valid_o),
        .core_resp_rdata_o (core_resp_rdata_o),
        .mem_req_valid_o   (mem_req_valid_o),
        .mem_req_ready_i   (mem_req_ready_i),
        .mem_req_we_o      (mem_req_we_o),
        .mem_req_addr_o    (mem_req_addr_o),
        .mem_req_wdata_o   (mem_req_wdata_o),
        .mem_resp_valid_i  (mem_resp_valid_i),
        .mem_resp_data_i   (mem_resp_data_i)
    );

    typedef struct {
        logic                  we;
        logic [31:0]           addr;
        logic [BLOCK_SIZE-1:0] data;
    } mreq_t;

    mreq_t                 mlog [$];
    logic [31:0]           sb_q [$];
    logic [BLOCK_SIZE-1:0] mem  [logic [31:0]];
    int                    checks    = 0;
    int                    failures  = 0;
    int                    stall_cnt = 0;
    int                    mem_lat   = 2;
    int                    rf_cd     = 0;
    logic [31:0]           rf_addr   = '0;

    function automatic logic [BLOCK_SIZE-1:0] get_line(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {(a + 32'd12) ^ 32'h5EED_0000, (a + 32'd8) ^ 32'h5EED_0000,
                (a + 32'd4) ^ 32'h5EED_0000, a ^ 32'h5EED_0000};
    endfunction

    function automatic logic [31:0] word_of(input logic [BLOCK_SIZE-1:0] line, input logic [31:0] a);
        logic [1:0] w;
        w = a[3:2];
        return line[32 * w +: 32];
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Memory model: ready/response decided on the falling edge, logged at handshake.
    initial begin
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
        forever begin
            @(negedge clk);
            mem_resp_valid_i = 1'b0;
            mem_resp_data_i  = '0;
            if (!rst_n) begin
                rf_cd           = 0;
                stall_cnt       = 0;
                mem_req_ready_i = 1'b0;
            end else begin
                if (rf_cd > 0) begin
                    rf_cd--;
                    if (rf_cd == 0) begin
                        mem_resp_valid_i = 1'b1;
                        mem_resp_data_i  = get_line(rf_addr);
                    end
                end
                if (mem_req_valid_o && stall_cnt > 0) begin
                    mem_req_ready_i = 1'b0;
                    stall_cnt--;
                end else begin
                    mem_req_ready_i = 1'b1;
                    if (mem_req_valid_o) begin
                        mlog.push_back('{mem_req_we_o, mem_req_addr_o, mem_req_wdata_o});
                        if (mem_req_we_o) begin
                            mem[mem_req_addr_o] = mem_req_wdata_o;
                        end else begin
                            rf_addr = mem_req_addr_o;
                            rf_cd   = mem_lat;
                        end
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        rst_n            = 1'b0;
        core_req_valid_i = 1'b0;
        core_req_we_i    = 1'b0;
        core_req_addr_i  = '0;
        core_req_wdata_i = '0;
        core_req_be_i    = '0;
        sb_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // lat counts falling edges from the cycle the request is presented to the response cycle.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input logic [31:0] exp, input string name,
                             output int lat);
        logic [31:0] exp_pop;
        bit          got;
        int          guard;
        guard = 0;
        while (!core_req_ready_o && guard < 100) begin
            tick();
            guard++;
        end
        sb_q.push_back(exp);
        core_req_valid_i = 1'b1;
        core_req_we_i    = we;
        core_req_addr_i  = addr;
        core_req_wdata_i = wdata;
        core_req_be_i    = be;
        tick();
        core_req_valid_i = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat < 200) begin
            if (core_resp_valid_o) got = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        exp_pop = sb_q.pop_front();
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_timeout: no response after %0d cycles, expected rdata %h", name, lat, exp_pop);
        end else begin
            if (core_resp_rdata_o !== exp_pop) begin
                failures++;
                $display("FAIL %s_rdata: got %h expected %h", name, core_resp_rdata_o, exp_pop);
            end
            checks++;
            if (core_req_ready_o !== 1'b1) begin
                failures++;
                $display("FAIL %s_ready_with_resp: got %b expected 1", name, core_req_ready_o);
            end
            tick();
            checks++;
            if (core_resp_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL %s_resp_pulse: got %b expected 0", name, core_resp_valid_o);
            end
        end
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        core_req_valid_i = 1'b0;
        core_req_we_i    = 1'b0;
        core_req_addr_i  = '0;
        core_req_wdata_i = '0;
        core_req_be_i    = '0;
        tick();
        checks++;
        if (core_req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 1", core_req_ready_o);
        end
        checks++;
        if ({core_resp_valid_o, mem_req_valid_o, mem_req_we_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_valids: got %b expected 000", {core_resp_valid_o, mem_req_valid_o, mem_req_we_o});
        end
        checks++;
        if ({mem_req_addr_o, mem_req_wdata_o, core_resp_rdata_o} !== '0) begin
            failures++;
            $display("FAIL reset_data: got addr %h wdata %h rdata %h expected all 0",
                     mem_req_addr_o, mem_req_wdata_o, core_resp_rdata_o);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cold_miss();
        int lat;
        int n0;
        mem[32'h1000] = {32'h5555_6666, 32'h1122_3344, 32'hDEAD_BEEF, 32'h0102_0304};
        n0 = mlog.size();
        do_access(1'b0, 32'h1004, 32'h0, 4'h0, 32'hDEAD_BEEF, "cold_load", lat);
        checks++;
        if (mlog.size() != n0 + 1) begin
            failures++;
            $display("FAIL cold_refill_count: got %0d expected %0d", mlog.size() - n0, 1);
        end else begin
            checks++;
            if (mlog[n0].we !== 1'b0 || mlog[n0].addr !== 32'h1000) begin
                failures++;
                $display("FAIL cold_refill_req: got we=%b addr=%h expected we=0 addr=00001000",
                         mlog[n0].we, mlog[n0].addr);
            end
        end
        n0 = mlog.size();
        do_access(1'b0, 32'h1004, 32'h0, 4'h0, 32'hDEAD_BEEF, "hit_load", lat);
        checks++;
        if (lat != 2) begin
            failures++;
            $display("FAIL hit_latency: got %0d expected 2", lat);
        end
        checks++;
        if (mlog.size() != n0) begin
            failures++;
            $display("FAIL hit_no_mem: got %0d requests expected 0", mlog.size() - n0);
        end
    endtask

    task automatic test_store_merge();
        int lat;
        int n0;
        n0 = mlog.size();
        do_access(1'b1, 32'h1008, 32'hAABB_CCDD, 4'b0011, 32'h0, "store_hit", lat);
        do_access(1'b0, 32'h1008, 32'h0, 4'h0, 32'h1122_CCDD, "merged_load", lat);
        do_access(1'b0, 32'h1004, 32'h0, 4'h0, 32'hDEAD_BEEF, "neighbour_load", lat);
        checks++;
        if (mlog.size() != n0) begin
            failures++;
            $display("FAIL store_no_mem: got %0d requests expected 0", mlog.size() - n0);
        end
    endtask

    task automatic test_writeback();
        int lat;
        int n0;
        logic [BLOCK_SIZE-1:0] l0;
        logic [BLOCK_SIZE-1:0] exp_wb;
        apply_reset();
        l0 = get_line(32'h0);
        do_access(1'b0, 32'h0000, 32'h0, 4'h0, word_of(l0, 32'h0), "wb_fill0", lat);
        do_access(1'b0, 32'h0400, 32'h0, 4'h0, word_of(get_line(32'h400), 32'h400), "wb_fill1", lat);
        do_access(1'b1, 32'h0000, 32'hCAFE_F00D, 4'hF, 32'h0, "wb_dirty", lat);
        exp_wb = {l0[BLOCK_SIZE-1:32], 32'hCAFE_F00D};
        n0 = mlog.size();
        do_access(1'b0, 32'h0800, 32'h0, 4'h0, word_of(get_line(32'h800), 32'h800), "wb_conflict", lat);
        checks++;
        if (mlog.size() != n0 + 2) begin
            failures++;
            $display("FAIL wb_req_count: got %0d expected 2", mlog.size() - n0);
        end else begin
            checks++;
            if (mlog[n0].we !== 1'b1 || mlog[n0].addr !== 32'h0 || mlog[n0].data !== exp_wb) begin
                failures++;
                $display("FAIL wb_req: got we=%b addr=%h data=%h expected we=1 addr=00000000 data=%h",
                         mlog[n0].we, mlog[n0].addr, mlog[n0].data, exp_wb);
            end
            checks++;
            if (mlog[n0 + 1].we !== 1'b0 || mlog[n0 + 1].addr !== 32'h800) begin
                failures++;
                $display("FAIL wb_then_refill: got we=%b addr=%h expected we=0 addr=00000800",
                         mlog[n0 + 1].we, mlog[n0 + 1].addr);
            end
        end
    endtask

    task automatic test_round_robin();
        int lat;
        int n0;
        apply_reset();
        do_access(1'b0, 32'h0000, 32'h0, 4'h0, word_of(get_line(32'h000), 32'h000), "rr_fill0", lat);
        do_access(1'b0, 32'h0400, 32'h0, 4'h0, word_of(get_line(32'h400), 32'h400), "rr_fill1", lat);
        n0 = mlog.size();
        do_access(1'b0, 32'h0804, 32'h0, 4'h0, word_of(get_line(32'h800), 32'h804), "rr_third", lat);
        do_access(1'b0, 32'h0400, 32'h0, 4'h0, word_of(get_line(32'h400), 32'h400), "rr_way1_kept", lat);
        do_access(1'b0, 32'h0C08, 32'h0, 4'h0, word_of(get_line(32'hC00), 32'hC08), "rr_fourth", lat);
        do_access(1'b0, 32'h080C, 32'h0, 4'h0, word_of(get_line(32'h800), 32'h80C), "rr_way0_kept", lat);
        checks++;
        if (mlog.size() != n0 + 2) begin
            failures++;
            $display("FAIL rr_refill_count: got %0d expected 2", mlog.size() - n0);
        end else begin
            checks++;
            if ({mlog[n0].we, mlog[n0].addr, mlog[n0 + 1].we, mlog[n0 + 1].addr} !== {1'b0, 32'h800, 1'b0, 32'hC00}) begin
                failures++;
                $display("FAIL rr_refill_addrs: got %h,%h expected 00000800,00000c00", mlog[n0].addr, mlog[n0 + 1].addr);
            end
        end
        n0 = mlog.size();
        do_access(1'b0, 32'h0400, 32'h0, 4'h0, word_of(get_line(32'h400), 32'h400), "rr_evicted", lat);
        checks++;
        if (mlog.size() != n0 + 1) begin
            failures++;
            $display("FAIL rr_evicted_miss: got %0d requests expected 1", mlog.size() - n0);
        end
    endtask

    task automatic test_wb_stall();
        int lat;
        int stalls;
        int guard;
        logic [BLOCK_SIZE-1:0] exp_wb;
        logic [31:0] exp_pop;
        apply_reset();
        do_access(1'b0, 32'h0000, 32'h0, 4'h0, word_of(get_line(32'h000), 32'h000), "st_fill0", lat);
        do_access(1'b0, 32'h0400, 32'h0, 4'h0, word_of(get_line(32'h400), 32'h400), "st_fill1", lat);
        do_access(1'b1, 32'h0000, 32'h0BAD_CAFE, 4'hF, 32'h0, "st_dirty", lat);
        exp_wb = {get_line(32'h0) >> 32, 32'h0BAD_CAFE};
        stall_cnt = 5;
        sb_q.push_back(word_of(get_line(32'h800), 32'h800));
        core_req_valid_i = 1'b1;
        core_req_we_i    = 1'b0;
        core_req_addr_i  = 32'h0800;
        tick();
        core_req_valid_i = 1'b0;
        stalls = 0;
        guard  = 0;
        while (!core_resp_valid_o && guard < 100) begin
            if (mem_req_valid_o && !mem_req_ready_i) begin
                stalls++;
                checks++;
                if (mem_req_we_o !== 1'b1 || mem_req_addr_o !== 32'h0 || mem_req_wdata_o !== exp_wb) begin
                    failures++;
                    $display("FAIL stall_hold: got we=%b addr=%h data=%h expected we=1 addr=00000000 data=%h",
                             mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, exp_wb);
                end
                checks++;
                if (core_req_ready_o !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_core_ready: got %b expected 0", core_req_ready_o);
                end
            end
            tick();
            guard++;
        end
        exp_pop = sb_q.pop_front();
        checks++;
        if (!core_resp_valid_o || core_resp_rdata_o !== exp_pop) begin
            failures++;
            $display("FAIL stall_resp: got valid=%b rdata=%h expected valid=1 rdata=%h",
                     core_resp_valid_o, core_resp_rdata_o, exp_pop);
        end
        checks++;
        if (stalls != 5) begin
            failures++;
            $display("FAIL stall_cycles: got %0d expected 5", stalls);
        end
        tick();
    endtask

    task automatic test_be_zero();
        int lat;
        int n0;
        logic [BLOCK_SIZE-1:0] l400;
        apply_reset();
        l400 = get_line(32'h400);
        do_access(1'b0, 32'h0000, 32'h0, 4'h0, word_of(get_line(32'h000), 32'h000), "bz_fill0", lat);
        do_access(1'b0, 32'h0400, 32'h0, 4'h0, word_of(l400, 32'h400), "bz_fill1", lat);
        do_access(1'b1, 32'h0404, 32'hFFFF_FFFF, 4'h0, 32'h0, "bz_store", lat);
        do_access(1'b0, 32'h0404, 32'h0, 4'h0, word_of(l400, 32'h404), "bz_unchanged", lat);
        n0 = mlog.size();
        do_access(1'b0, 32'h0800, 32'h0, 4'h0, word_of(get_line(32'h800), 32'h800), "bz_evict0", lat);
        do_access(1'b0, 32'h0C00, 32'h0, 4'h0, word_of(get_line(32'hC00), 32'hC00), "bz_evict1", lat);
        checks++;
        if (mlog.size() != n0 + 3) begin
            failures++;
            $display("FAIL bz_req_count: got %0d expected 3", mlog.size() - n0);
        end else begin
            checks++;
            if (mlog[n0 + 1].we !== 1'b1 || mlog[n0 + 1].addr !== 32'h400 || mlog[n0 + 1].data !== l400) begin
                failures++;
                $display("FAIL bz_dirty_wb: got we=%b addr=%h expected we=1 addr=00000400",
                         mlog[n0 + 1].we, mlog[n0 + 1].addr);
            end
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        int n0;
        int guard;
        int resp_seen;
        apply_reset();
        stall_cnt = 50;
        core_req_valid_i = 1'b1;
        core_req_we_i    = 1'b0;
        core_req_addr_i  = 32'h1004;
        tick();
        core_req_valid_i = 1'b0;
        guard = 0;
        while (!mem_req_valid_o && guard < 20) begin
            tick();
            guard++;
        end
        checks++;
        if (!mem_req_valid_o) begin
            failures++;
            $display("FAIL midop_reach_req: got mem_req_valid=0 expected 1");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req_valid_o !== 1'b0 || core_req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL midop_async_drop: got valid=%b ready=%b expected valid=0 ready=1",
                     mem_req_valid_o, core_req_ready_o);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        mem_lat = 8;
        n0 = mlog.size();
        core_req_valid_i = 1'b1;
        core_req_addr_i  = 32'h1004;
        tick();
        core_req_valid_i = 1'b0;
        guard = 0;
        while (mlog.size() == n0 && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        rst_n = 1'b0;
        resp_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (core_resp_valid_o) resp_seen++;
            tick();
            if (i == 2) rst_n = 1'b1;
        end
        checks++;
        if (resp_seen != 0) begin
            failures++;
            $display("FAIL midop_no_resp: got %0d responses expected 0", resp_seen);
        end
        mem_lat = 2;
        n0 = mlog.size();
        do_access(1'b0, 32'h1004, 32'h0, 4'h0, word_of(get_line(32'h1000), 32'h1004), "after_reset_load", lat);
        checks++;
        if (mlog.size() != n0 + 1) begin
            failures++;
            $display("FAIL after_reset_miss: got %0d requests expected 1", mlog.size() - n0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_store_merge();
        test_writeback();
        test_round_robin();
        test_wb_stall();
        test_be_zero();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
